// File: rtl/priority_arbiter_fsm_if.sv
// Request/grant bundle between requesters and priority_arbiter_fsm.
// Requesters drive req through master; the arbiter drives the registered grant side through slave.
interface priority_arbiter_fsm_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] Y;
    logic       z;
    logic       tmo;

    modport master (
        output req,
        input  grant,
        input  Y,
        input  z,
        input  tmo
    );

    modport slave (
        input  req,
        output grant,
        output Y,
        output z,
        output tmo
    );
endinterface

// File: rtl/priority_arbiter_fsm.sv
// 8-way arbiter FSM (IDLE/GRANT/RELEASE), fixed priority, or rotating priority with ROUND_ROBIN_EN.
// Latency: grant registered 1 cycle after req; each grant is followed by a 1-cycle RELEASE gap.
// Backpressure: none; a grant is held while req[Y] stays high, for at most HOLD_MAX cycles, then force-released.
module priority_arbiter_fsm #(
    parameter int HOLD_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    priority_arbiter_fsm_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_grant, w_grant_nxt;
    logic [2:0] r_y,     w_y_nxt;
    logic       r_z,     w_z_nxt;
    logic       r_tmo,   w_tmo_nxt;
    logic [7:0] r_hold,  w_hold_nxt;
    logic [2:0] r_last,  w_last_nxt;
    logic       w_enter;

    logic [2:0] w_ptr;
    logic [7:0] w_last_oh;
    logic [7:0] w_arb_req;
    logic       w_found;
    logic [2:0] w_win;

    // Search downward from p, wrapping modulo 8; first set bit wins.
    function automatic logic [2:0] f_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       hit;
        f_pick = p;
        hit    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p - 3'(k);
            if (!hit && r[idx]) begin
                f_pick = idx;
                hit    = 1'b1;
            end
        end
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [2:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'd7;
        end else if (w_enter) begin
            r_ptr <= w_win - 3'd1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 3'd7;
`endif

    // A timed-out requester steps aside for one arbitration if anyone else is waiting.
    assign w_last_oh = 8'd1 << r_last;
    assign w_arb_req = (r_state == RELEASE && r_tmo && ((bus.req & ~w_last_oh) != 8'd0))
                     ? (bus.req & ~w_last_oh) : bus.req;
    assign w_found   = |w_arb_req;
    assign w_win     = f_pick(w_arb_req, w_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_y_nxt     = r_y;
        w_z_nxt     = r_z;
        w_tmo_nxt   = 1'b0;
        w_hold_nxt  = r_hold;
        w_last_nxt  = r_last;
        w_enter     = 1'b0;

        unique case (r_state)
            IDLE, RELEASE: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 8'd0;
                w_y_nxt     = 3'd0;
                w_z_nxt     = 1'b0;
                if (w_found) begin
                    w_enter     = 1'b1;
                    w_state_nxt = GRANT;
                    w_grant_nxt = 8'd1 << w_win;
                    w_y_nxt     = w_win;
                    w_z_nxt     = 1'b1;
                    w_hold_nxt  = 8'd0;
                    w_last_nxt  = w_win;
                end
            end
            GRANT: begin
                if (!bus.req[r_y] || r_hold == HOLD_LAST) begin
                    // A drop on the last allowed cycle still counts as a normal release.
                    w_state_nxt = RELEASE;
                    w_grant_nxt = 8'd0;
                    w_y_nxt     = 3'd0;
                    w_z_nxt     = 1'b0;
                    w_tmo_nxt   = bus.req[r_y];
                end else begin
                    w_hold_nxt  = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 8'd0;
                w_y_nxt     = 3'd0;
                w_z_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= 8'd0;
            r_y     <= 3'd0;
            r_z     <= 1'b0;
            r_tmo   <= 1'b0;
            r_hold  <= 8'd0;
            r_last  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_y     <= w_y_nxt;
            r_z     <= w_z_nxt;
            r_tmo   <= w_tmo_nxt;
            r_hold  <= w_hold_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.grant = r_grant;
    assign bus.Y     = r_y;
    assign bus.z     = r_z;
    assign bus.tmo   = r_tmo;

endmodule

// File: tb/tb_priority_arbiter_fsm.sv
// Directed bench for priority_arbiter_fsm with HOLD_MAX=4; expected values are hand-derived.
module tb_priority_arbiter_fsm;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    priority_arbiter_fsm_if u_if ();

    priority_arbiter_fsm #(.HOLD_MAX(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] y,
                              input logic zv, input logic t);
        chk({tag, ".grant"}, 32'(u_if.grant), 32'(g));
        chk({tag, ".Y"},     32'(u_if.Y),     32'(y));
        chk({tag, ".z"},     32'(u_if.z),     32'(zv));
        chk({tag, ".tmo"},   32'(u_if.tmo),   32'(t));
    endtask

    // Advance one edge and sample 1 time unit later; grant must be zero/one-hot and match z.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot0", 32'($onehot0(u_if.grant)), 32'd1);
        chk("z_vs_grant", 32'(u_if.z), 32'(u_if.grant != 8'd0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Entered GRANT for y this cycle with the request held: expect 4 held cycles, forced release, next grant.
    task automatic held_grant(input string tag, input logic [2:0] y);
        expect_out({tag, ".enter"}, 8'd1 << y, y, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out({tag, ".hold"}, 8'd1 << y, y, 1'b1, 1'b0);
        end
        tick();
        expect_out({tag, ".forced"}, 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic drain();
        u_if.req = 8'h00;
        tick();
        tick();
        expect_out("drain.idle", 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] rr_exp [0:8];
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        u_if.req = 8'h00;
        #12;
        expect_out("por", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        tick();
        expect_out("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

        // Highest index wins, one cycle after req.
        u_if.req = 8'b0010_0100;
        tick();
        expect_out("prio", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
        u_if.req = 8'h00;
        tick();
        expect_out("prio.release", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("prio.idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Sole requester times out and is re-granted after the dead cycle.
        do_reset();
        u_if.req = 8'h08;
        tick();
        held_grant("sole3", 3'd3);
        expect_out("sole3.regrant", 8'h08, 3'd3, 1'b1, 1'b0);
        drain();

        // Timed-out req[7] is masked so req[1] wins next.
        do_reset();
        u_if.req = 8'h82;
        tick();
        held_grant("mask7", 3'd7);
        expect_out("mask7.next", 8'h02, 3'd1, 1'b1, 1'b0);
        drain();

        // Other requests churn without disturbing grant; drop on last cycle is a normal release.
        do_reset();
        u_if.req = 8'h10;
        tick();
        expect_out("edge.enter", 8'h10, 3'd4, 1'b1, 1'b0);
        u_if.req = 8'h11;
        tick();
        expect_out("edge.churn1", 8'h10, 3'd4, 1'b1, 1'b0);
        u_if.req = 8'hB3;
        tick();
        expect_out("edge.churn2", 8'h10, 3'd4, 1'b1, 1'b0);
        u_if.req = 8'h13;
        tick();
        expect_out("edge.last", 8'h10, 3'd4, 1'b1, 1'b0);
        u_if.req = 8'h03;
        tick();
        expect_out("edge.normal", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("edge.next", 8'h02, 3'd1, 1'b1, 1'b0);
        drain();

        // Asynchronous reset mid-grant, then re-arbitration on the first edge.
        do_reset();
        u_if.req = 8'h40;
        tick();
        expect_out("arst.pre", 8'h40, 3'd6, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("arst.async", 8'h00, 3'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        expect_out("arst.first", 8'h40, 3'd6, 1'b1, 1'b0);
        drain();

        // All requesting: rotating order in the RR build, 7/6 alternation in fixed priority.
`ifdef ROUND_ROBIN_EN
        rr_exp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
        rr_exp = '{3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
`endif
        do_reset();
        u_if.req = 8'hFF;
        tick();
        for (int i = 0; i < 8; i++) begin
            held_grant($sformatf("allreq%0d", i), rr_exp[i]);
        end
        expect_out("allreq.last", 8'd1 << rr_exp[8], rr_exp[8], 1'b1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/priority_arbiter_fsm.md
PRIORITY_ARBITER_FSM -- requirements
Module: priority_arbiter_fsm

Interface
REQ-001 Parameter HOLD_MAX SHALL have default 16 and set the maximum number of cycles a grant is held; legal range 1..255.
REQ-002 clk SHALL be an input, 1 bit: the single rising-edge clock for all state.
REQ-003 rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-004 req SHALL be an input, 8 bits: one request line per requester, req[7]..req[0].
REQ-005 grant SHALL be an output, 8 bits: registered one-hot grant vector, or all zero.
REQ-006 Y SHALL be an output, 3 bits: registered index of the granted requester.
REQ-007 z SHALL be an output, 1 bit: registered grant-valid flag, high when grant is non-zero.
REQ-008 tmo SHALL be an output, 1 bit: registered one-cycle pulse on a forced release.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-010 In IDLE with req==0, the FSM SHALL remain in IDLE with grant=0, z=0, Y=3'b000.
REQ-011 In IDLE with req!=0, the next edge SHALL enter GRANT with the winner's grant bit set, Y=winner and z=1 (1-cycle latency from req to grant).
REQ-012 Default winner selection SHALL be fixed priority: the highest set req index wins (req[7] highest, req[0] lowest).
REQ-013 Each grant SHALL be tracked by an 8-bit hold counter that clears on grant entry and increments once per cycle in GRANT.
REQ-014 In GRANT, grant, Y and z SHALL stay stable while req[Y]=1 and hold count < HOLD_MAX-1.
REQ-015 If req[Y]=0 while in GRANT, the next edge SHALL enter RELEASE with grant=0, z=0, Y=0 (normal release).
REQ-016 If req[Y]=1 and hold count == HOLD_MAX-1, the next edge SHALL enter RELEASE, clear the grant and assert tmo for exactly one cycle (forced release).
REQ-017 If req[Y] falls in the same cycle the counter reaches HOLD_MAX-1, the release SHALL be treated as normal, with tmo=0.
REQ-018 RELEASE SHALL last exactly one cycle with grant=0 and SHALL arbitrate as in IDLE at its end, giving a one-cycle dead gap between consecutive grants.
REQ-019 After a forced release, arbitration in RELEASE SHALL mask the timed-out requester if any other req bit is set; if it is the sole requester, it SHALL be re-granted.
REQ-020 Requests arriving or dropping in GRANT for non-granted indices SHALL NOT affect the current grant.
REQ-021 grant SHALL always be zero or one-hot, and grant[Y] SHALL equal z in every cycle.

Reset
REQ-022 Asserting rst_n low SHALL immediately force state=IDLE, grant=0, Y=0, z=0, tmo=0, hold count=0, and round-robin pointer=7, including mid-grant.
REQ-023 After rst_n deasserts, the first arbitration SHALL occur on the first rising clk edge with req!=0.

Configuration
REQ-024 Macro ROUND_ROBIN_EN, when defined, SHALL replace fixed priority with rotating priority; when undefined, REQ-012 applies unchanged.
REQ-025 With ROUND_ROBIN_EN, a pointer P (reset 7) SHALL give the search order P, P-1, ..., wrapping modulo 8, and P SHALL become (winner-1) mod 8 on each grant.
REQ-026 With ROUND_ROBIN_EN, the REQ-019 masking SHALL still apply, and all other timing SHALL be identical to the fixed-priority build.

Verification
REQ-027 The bench SHALL apply req=8'b00100100 from IDLE and check grant=8'b00100000, Y=5, z=1 one cycle later.
REQ-028 The bench SHALL, with HOLD_MAX=4 and req[3] held alone, check the grant is held 4 cycles, then RELEASE with tmo=1 for 1 cycle, then req[3] is re-granted.
REQ-029 The bench SHALL, with HOLD_MAX=4, req[7] and req[1] held, check that after req[7] times out the next grant is Y=1, not 7.
REQ-030 The bench SHALL drop req[Y] in the same cycle the counter hits HOLD_MAX-1 and check for a normal release with tmo=0.
REQ-031 The bench SHALL pull rst_n low mid-GRANT and check that grant, z and Y go to 0 asynchronously before the next clk edge.
REQ-032 With ROUND_ROBIN_EN, the bench SHALL hold req=8'hFF with per-grant release and check the grant order 7,6,5,...,0,7.
